// File: rtl/multiport_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : multiport_mem_scheduler
// Brief   : Valid/ready request front-end for a multiport RAM with round-robin
//           same-address hazard resolution and pipelined read responses.
// Revision: 1.0
// ============================================================================
module multiport_mem_scheduler #(
    parameter int mem_width  = 12,
    parameter int addr_width = 12,
    parameter int port_count = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [port_count-1:0]            req_valid,
    output logic [port_count-1:0]            req_ready,
    input  logic [port_count-1:0]            req_write,
    input  logic [addr_width*port_count-1:0] req_addr,
    input  logic [mem_width*port_count-1:0]  req_wdata,
    output logic [port_count-1:0]            rsp_valid,
    output logic [mem_width*port_count-1:0]  rsp_rdata,
    output logic [addr_width*port_count-1:0] ram_address,
    output logic [mem_width*port_count-1:0]  ram_datain,
    output logic [port_count-1:0]            ram_mem_write,
    input  logic [mem_width*port_count-1:0]  ram_dataout
);

    localparam int PTR_W = $clog2(port_count);

    logic [PTR_W-1:0]                      rr_ptr_q, rr_ptr_d;
    logic [port_count-1:0]                 grant, conflicted, accept;
    logic [port_count-1:0][RD_LATENCY:0]   rd_pipe_q, rd_pipe_d;
    logic [port_count-1:0]                 rsp_valid_q, rsp_valid_d;
    logic [mem_width*port_count-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic [addr_width*port_count-1:0]      ram_address_q, ram_address_d;
    logic [mem_width*port_count-1:0]       ram_datain_q, ram_datain_d;
    logic [port_count-1:0]                 ram_mem_write_q, ram_mem_write_d;

    // Circular distance from the round-robin pointer; smaller wins a conflict.
    function automatic int prio(input int idx, input logic [PTR_W-1:0] ptr);
        return (idx + port_count - int'(ptr)) % port_count;
    endfunction

    always_comb begin
        grant      = '0;
        conflicted = '0;
        rr_ptr_d   = rr_ptr_q;
        for (int i = 0; i < port_count; i++) begin
            grant[i] = req_valid[i];
            for (int j = 0; j < port_count; j++) begin
                if (j != i && req_valid[i] && req_valid[j] &&
                    req_addr[i*addr_width +: addr_width] == req_addr[j*addr_width +: addr_width] &&
                    (req_write[i] || req_write[j])) begin
                    conflicted[i] = 1'b1;
                    if (prio(j, rr_ptr_q) < prio(i, rr_ptr_q)) grant[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < port_count; i++) begin
            if (grant[i] && conflicted[i]) rr_ptr_d = PTR_W'((i + 1) % port_count);
        end
    end

    assign req_ready = grant & {port_count{reset}};
    assign accept    = req_valid & req_ready;

    always_comb begin
        ram_address_d   = ram_address_q;
        ram_datain_d    = ram_datain_q;
        ram_mem_write_d = '0;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_valid_d     = '0;
        rd_pipe_d       = '0;
        for (int i = 0; i < port_count; i++) begin
            if (accept[i]) begin
                ram_address_d[i*addr_width +: addr_width] = req_addr[i*addr_width +: addr_width];
                ram_datain_d[i*mem_width +: mem_width]    = req_wdata[i*mem_width +: mem_width];
                ram_mem_write_d[i]                        = req_write[i];
            end
            // Stage 0 tags a fresh read; the top stage lines up with valid RAM data.
            rd_pipe_d[i] = {rd_pipe_q[i][RD_LATENCY-1:0], accept[i] & ~req_write[i]};
            rsp_valid_d[i] = rd_pipe_q[i][RD_LATENCY];
            if (rd_pipe_q[i][RD_LATENCY]) begin
                rsp_rdata_d[i*mem_width +: mem_width] = ram_dataout[i*mem_width +: mem_width];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q        <= '0;
            rd_pipe_q       <= '0;
            rsp_valid_q     <= '0;
            rsp_rdata_q     <= '0;
            ram_address_q   <= '0;
            ram_datain_q    <= '0;
            ram_mem_write_q <= '0;
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            rd_pipe_q       <= rd_pipe_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            ram_address_q   <= ram_address_d;
            ram_datain_q    <= ram_datain_d;
            ram_mem_write_q <= ram_mem_write_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign ram_address   = ram_address_q;
    assign ram_datain    = ram_datain_q;
    assign ram_mem_write = ram_mem_write_q;

endmodule
`default_nettype wire

// File: tb/tb_multiport_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_multiport_mem_scheduler
// Brief   : Scoreboard bench with a RAM model and a reference memory/arbiter.
// Revision: 1.0
// ============================================================================
module tb_multiport_mem_scheduler;

    localparam int MW = 12;
    localparam int AW = 12;
    localparam int N  = 2;
    localparam int RD = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid = '0, req_ready, req_write = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*MW-1:0]   req_wdata = '0;
    logic [N-1:0]      rsp_valid, ram_mem_write;
    logic [N*MW-1:0]   rsp_rdata, ram_datain, ram_dataout;
    logic [N*AW-1:0]   ram_address;

    multiport_mem_scheduler #(.mem_width(MW), .addr_width(AW), .port_count(N), .RD_LATENCY(RD)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_address(ram_address), .ram_datain(ram_datain),
        .ram_mem_write(ram_mem_write), .ram_dataout(ram_dataout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [MW-1:0] init_val(input int a);
        return MW'((a * 37) ^ 'h5A5);
    endfunction

    // RAM model: synchronous write, registered read with RD stages.
    logic [MW-1:0] ram_mem [1 << AW];
    logic [MW-1:0] rd_pipe [N][RD];
    bit            mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < (1 << AW); a++) ram_mem[a] <= init_val(a);
            mem_ready <= 1'b1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (ram_mem_write[i]) ram_mem[ram_address[i*AW +: AW]] <= ram_datain[i*MW +: MW];
                rd_pipe[i][0] <= ram_mem[ram_address[i*AW +: AW]];
                for (int k = 1; k < RD; k++) rd_pipe[i][k] <= rd_pipe[i][k-1];
            end
        end
    end
    always_comb begin
        ram_dataout = '0;
        for (int i = 0; i < N; i++) ram_dataout[i*MW +: MW] = rd_pipe[i][RD-1];
    end

    typedef struct packed {
        logic [31:0]   cyc;
        logic [MW-1:0] data;
    } exp_t;

    exp_t          exp_q [N][$];
    logic [MW-1:0] ref_mem [1 << AW];
    int            rr_m = 0;
    logic [N-1:0]  exp_mw = '0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference arbiter: walk ports in round-robin order; a port loses if an
    // earlier valid port in that order targets the same address and either writes.
    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input logic [N-1:0] w,
                                                 input logic [N*AW-1:0] a, input int rr, output int rr_next);
        logic [N-1:0] g;
        g = '0;
        rr_next = rr;
        for (int k = 0; k < N; k++) begin
            int  p;
            bit  won, clash;
            p = (rr + k) % N;
            won = v[p];
            clash = 1'b0;
            for (int m = 0; m < N; m++) begin
                int q;
                q = (rr + m) % N;
                if (q != p && v[p] && v[q] && a[q*AW +: AW] == a[p*AW +: AW] && (w[p] || w[q])) begin
                    clash = 1'b1;
                    if (m < k) won = 1'b0;
                end
            end
            g[p] = won;
            if (won && clash) rr_next = (p + 1) % N;
        end
        return g;
    endfunction

    task automatic step(input logic rst_v, input logic [N-1:0] v, input logic [N-1:0] w,
                        input logic [N*AW-1:0] a, input logic [N*MW-1:0] d, output logic [N-1:0] acc);
        logic [N-1:0] g;
        int           rr_n;
        @(negedge clk);
        reset = rst_v; req_valid = v; req_write = w; req_addr = a; req_wdata = d;
        #1;
        g = model_grant(v, w, a, rr_m, rr_n);
        if (!rst_v) g = '0;
        chk(req_ready == g, "req_ready", 64'(req_ready), 64'(g));
        acc = v & req_ready;
        if (!rst_v) begin
            chk(rsp_valid == '0 && rsp_rdata == '0, "reset_rsp", 64'(rsp_rdata), 64'(0));
            chk(ram_address == '0 && ram_datain == '0 && ram_mem_write == '0, "reset_ram",
                64'({ram_address, ram_datain, ram_mem_write}), 64'(0));
            for (int i = 0; i < N; i++) exp_q[i].delete();
            rr_m   = 0;
            exp_mw = '0;
            return;
        end
        rr_m = rr_n;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && !w[i]) exp_q[i].push_back('{cyc: 32'(cyc + 2 + RD), data: ref_mem[a[i*AW +: AW]]});
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i] && w[i]) ref_mem[a[i*AW +: AW]] = d[i*MW +: MW];
        end
        exp_mw = acc & w;
    endtask

    // Monitor: sampled away from the edge, independent of the driver.
    always @(posedge clk) begin
        #2;
        chk(ram_mem_write == exp_mw, "ram_mem_write", 64'(ram_mem_write), 64'(exp_mw));
        for (int i = 0; i < N; i++) begin
            while (exp_q[i].size() > 0 && int'(exp_q[i][0].cyc) < cyc) begin
                chk(1'b0, "rsp_missing", 64'(0), 64'(exp_q[i][0].data));
                void'(exp_q[i].pop_front());
            end
            if (rsp_valid[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk(1'b0, "rsp_unexpected", 64'(rsp_rdata[i*MW +: MW]), 64'(0));
                end else begin
                    exp_t e;
                    e = exp_q[i].pop_front();
                    chk(int'(e.cyc) == cyc, "rsp_cycle", 64'(cyc), 64'(e.cyc));
                    chk(rsp_rdata[i*MW +: MW] == e.data, "rsp_rdata", 64'(rsp_rdata[i*MW +: MW]), 64'(e.data));
                end
            end
        end
    end

    logic [N-1:0]    acc;
    logic [N-1:0]    hv, hw, pend;
    logic [N*AW-1:0] ha;
    logic [N*MW-1:0] hd;

    task automatic idle(input int n);
        logic [N-1:0] x;
        for (int k = 0; k < n; k++) step(1'b1, '0, '0, '0, '0, x);
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) ref_mem[a] = init_val(a);

        // Reset with both requesters asking, then release with distinct addresses.
        for (int k = 0; k < 3; k++) step(1'b0, 2'b11, 2'b00, {12'h002, 12'h001}, '0, acc);
        step(1'b1, 2'b11, 2'b00, {12'h021, 12'h020}, '0, acc);
        idle(2);

        // Write p0 then read p1 of the same address on the next cycle.
        step(1'b1, 2'b01, 2'b01, {12'h000, 12'h001}, {12'h000, 12'hFF8}, acc);
        step(1'b1, 2'b10, 2'b00, {12'h001, 12'h000}, '0, acc);
        idle(4);

        // Write/write hazard on address 4: p0 first, then p1.
        step(1'b1, 2'b11, 2'b11, {12'h004, 12'h004}, {12'h222, 12'h111}, acc);
        step(1'b1, 2'b10, 2'b10, {12'h004, 12'h004}, {12'h222, 12'h111}, acc);
        idle(3);
        chk(ram_mem[4] == 12'h222, "ram4_final", 64'(ram_mem[4]), 64'h222);

        // Read/read on one address is hazard-free.
        step(1'b1, 2'b11, 2'b00, {12'h007, 12'h007}, '0, acc);
        idle(4);

        // Back-to-back reads on p0.
        for (int k = 0; k < 4; k++) step(1'b1, 2'b01, 2'b00, {12'h000, 12'(16 + k)}, '0, acc);
        idle(5);

        // Random traffic over a small address window to provoke hazards.
        pend = '0; hv = '0; hw = '0; ha = '0; hd = '0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    hv[i] = ($urandom_range(3) != 0);
                    hw[i] = $urandom_range(1);
                    ha[i*AW +: AW] = AW'($urandom_range(3));
                    hd[i*MW +: MW] = MW'($urandom);
                end
            end
            step(1'b1, hv, hw, ha, hd, acc);
            pend = hv & ~acc;
        end
        idle(6);

        // Reset while a read is in flight: its response must never appear.
        step(1'b1, 2'b01, 2'b00, {12'h000, 12'h030}, '0, acc);
        for (int k = 0; k < 3; k++) step(1'b0, '0, '0, '0, '0, acc);
        idle(8);
        for (int i = 0; i < N; i++) chk(exp_q[i].size() == 0, "drain", 64'(exp_q[i].size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
